// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage
//   Pipeline register between fetch and decode. It has one extra skid entry,
//   so in_ready comes straight from a flop and never depends on out_ready.
//   This keeps fetch off decode's stall timing path and still passes one
//   instruction per cycle when nothing stalls.
//
// Optional feature: define IF_ID_PERF_CNT_EN to add the stall_cnt and
//   flush_cnt performance counters. Both saturate at all-ones.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   flush          squash the main and skid entries (redirect)
//   in_valid/in_ready, pc_in, instr_in       fetch-side handshake
//   out_valid/out_ready, pc_out, instr_out   decode-side handshake (registered)
//   stall_cnt, flush_cnt                     perf counters (IF_ID_PERF_CNT_EN only)
module if_id_skid_stage #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [ILEN-1:0] instr_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic [ILEN-1:0] instr_out
);

    // The main entry lives directly in the output registers (out_valid,
    // pc_out, instr_out). instr_out is rewritten with NOP_INSTR whenever
    // main empties, so decode always sees a bubble on an invalid slot.
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_instr;

    logic in_fire;
    logic out_fire;

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            pc_out     <= '0;
            instr_out  <= NOP_INSTR;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (flush) begin
            // Flush wins over any handshake in the same cycle. pc_out is kept.
            out_valid  <= 1'b0;
            instr_out  <= NOP_INSTR;
            skid_valid <= 1'b0;
        end else if (out_fire) begin
            if (skid_valid) begin
                // The skid entry is older than anything fetch could offer.
                // in_ready is low here, so no input can fire.
                pc_out     <= skid_pc;
                instr_out  <= skid_instr;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                pc_out    <= pc_in;
                instr_out <= instr_in;
            end else begin
                out_valid <= 1'b0;
                instr_out <= NOP_INSTR;
            end
        end else if (out_valid) begin
            // Decode is stalled. An accepted input overflows into the skid entry.
            if (in_fire) begin
                skid_valid <= 1'b1;
                skid_pc    <= pc_in;
                skid_instr <= instr_in;
            end
        end else if (in_fire) begin
            out_valid <= 1'b1;
            pc_out    <= pc_in;
            instr_out <= instr_in;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage. Inputs are driven on the falling edge
// and outputs are checked on the falling edge, half a cycle after the
// rising edge that updated them.
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] NOP1 = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] pc_in, instr_in, pc_out, instr_out;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    // 64-bit instance used for the parameter sweep
    logic        flush_w, in_valid_w, out_ready_w, in_ready_w, out_valid_w;
    logic [63:0] pc_in_w, pc_out_w;
    logic [31:0] instr_in_w, instr_out_w;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_w, flush_cnt_w;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_id_skid_stage u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out),
`ifdef IF_ID_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .instr_out(instr_out)
    );

    if_id_skid_stage #(.XLEN(64), .ILEN(32), .NOP_INSTR(32'h0000_0001)) u_dut_w (
        .clk(clk), .rst(rst), .flush(flush_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .pc_in(pc_in_w), .instr_in(instr_in_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .pc_out(pc_out_w),
`ifdef IF_ID_PERF_CNT_EN
        .stall_cnt(stall_cnt_w), .flush_cnt(flush_cnt_w),
`endif
        .instr_out(instr_out_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        pc_in     = pc;
        instr_in  = 32'hA000_0000 | pc;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b0;
        pc_in_w = '0; instr_in_w = '0;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr_out}, {32'd0, NOP});
        chk("rst_pc", {32'd0, pc_out}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("w_rst_instr", {32'd0, instr_out_w}, {32'd0, NOP1});
        @(negedge clk);
        rst = 1'b0;

        // Streaming: 0x0, 0x4, 0x8 back to back
        drive(1'b1, 32'h0, 1'b1, 1'b0); step();
        chk("str0_valid", {63'd0, out_valid}, 64'd1);
        chk("str0_pc", {32'd0, pc_out}, 64'h0);
        chk("str0_instr", {32'd0, instr_out}, 64'hA000_0000);
        drive(1'b1, 32'h4, 1'b1, 1'b0); step();
        chk("str1_pc", {32'd0, pc_out}, 64'h4);
        chk("str1_valid", {63'd0, out_valid}, 64'd1);
        drive(1'b1, 32'h8, 1'b1, 1'b0); step();
        chk("str2_pc", {32'd0, pc_out}, 64'h8);
        chk("str2_instr", {32'd0, instr_out}, 64'hA000_0008);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_instr", {32'd0, instr_out}, {32'd0, NOP});
        chk("drain_pc_kept", {32'd0, pc_out}, 64'h8);

        // Backpressure: main holds 0x10, 0x14 goes into skid
        drive(1'b1, 32'h10, 1'b0, 1'b0); step();
        chk("bp_pc10", {32'd0, pc_out}, 64'h10);
        chk("bp_rdy1", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'h14, 1'b0, 1'b0); step();
        chk("bp_rdy0", {63'd0, in_ready}, 64'd0);
        chk("bp_pc_hold", {32'd0, pc_out}, 64'h10);
        step();  // stall with skid full, 0x14 still offered but not taken
        chk("bp_stall_pc", {32'd0, pc_out}, 64'h10);
        chk("bp_stall_rdy", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h18, 1'b1, 1'b0); step();
        chk("bp_pc14", {32'd0, pc_out}, 64'h14);
        chk("bp_rdy_back", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        in_valid = 1'b1; pc_in = 32'h18; instr_in = 32'hA000_0018;
        step();
        chk("bp_pc18", {32'd0, pc_out}, 64'h18);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush with both entries full and 0x28 offered
        drive(1'b1, 32'h20, 1'b0, 1'b0); step();
        drive(1'b1, 32'h24, 1'b0, 1'b0); step();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'h28, 1'b1, 1'b1); step();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_instr", {32'd0, instr_out}, {32'd0, NOP});
        chk("fl_pc_kept", {32'd0, pc_out}, 64'h20);
        chk("fl_rdy", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        chk("fl_no28", {63'd0, out_valid}, 64'd0);
        // Flush discards an input fire into an empty main
        drive(1'b1, 32'h30, 1'b1, 1'b1); step();
        chk("fl_drop_in", {63'd0, out_valid}, 64'd0);

        // Async reset mid-stall with both entries full
        drive(1'b1, 32'h40, 1'b0, 1'b0); step();
        drive(1'b1, 32'h44, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_instr", {32'd0, instr_out}, {32'd0, NOP});
        chk("arst_pc", {32'd0, pc_out}, 64'd0);
        chk("arst_rdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h50, 1'b0, 1'b0); step();
        chk("post_rst_pc", {32'd0, pc_out}, 64'h50);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        chk("post_rst_no44", {63'd0, out_valid}, 64'd0);

        // 64-bit instance
        in_valid_w = 1'b1; pc_in_w = 64'hFFFF_FFFF_0000_0000;
        instr_in_w = 32'h1234_5678; out_ready_w = 1'b1;
        step();
        chk("w_pc", pc_out_w, 64'hFFFF_FFFF_0000_0000);
        chk("w_instr", {32'd0, instr_out_w}, 64'h1234_5678);
        in_valid_w = 1'b0;
        step();
        chk("w_bubble", {32'd0, instr_out_w}, {32'd0, NOP1});
        chk("w_pc_kept", pc_out_w, 64'hFFFF_FFFF_0000_0000);

`ifdef IF_ID_PERF_CNT_EN
        rst = 1'b1; #1; @(negedge clk); rst = 1'b0;
        chk("pc_rst_stall", {32'd0, stall_cnt}, 64'd0);
        drive(1'b1, 32'h60, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0); step(); step(); step();
        drive(1'b0, 32'h0, 1'b1, 1'b1); step(); step();
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        chk("pc_stall3", {32'd0, stall_cnt}, 64'd3);
        chk("pc_flush2", {32'd0, flush_cnt}, 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
